// File: rtl/pktcnt_snap_pkg.sv
// Shared types and header layout for the packet-counter snapshot scheduler.
package pktcnt_snap_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_e;

  localparam logic [15:0] MAGIC_DEF     = 16'h0C47;
  localparam int          HDR_MAGIC_LSB = 48;
  localparam int          HDR_NCNT_LSB  = 40;
  localparam int          HDR_SEQ_LSB   = 0;

  // Word index spans 0..NUM_CNT (header plus one word per counter).
  function automatic int widx_w(input int num_cnt);
    return (num_cnt < 1) ? 1 : $clog2(num_cnt + 1);
  endfunction

  function automatic logic [63:0] mk_header(input logic [15:0] magic,
                                            input logic [7:0]  ncnt,
                                            input logic [31:0] seq);
    logic [63:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = magic;
    h[HDR_NCNT_LSB  +: 8]  = ncnt;
    h[HDR_SEQ_LSB   +: 32] = seq;
    return h;
  endfunction

endpackage

// File: rtl/snapshot_interval_timer.sv
// Free-running snapshot interval timer: one-cycle expire pulse every `interval` clocks.
module snapshot_interval_timer #(
  parameter int INTERVAL_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  expire
);

  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  tmr_en;

  assign tmr_en = (interval != '0);
  assign expire = tmr_en && (cnt_q == INTERVAL_W'(1));

  // A count of 0 is left over from a disabled period; reload so a newly
  // programmed interval starts counting instead of wrapping.
  always_comb begin
    cnt_d = cnt_q - INTERVAL_W'(1);
    if (!tmr_en || cnt_q <= INTERVAL_W'(1))
      cnt_d = interval;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= interval;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pktcnt_snapshot_sched.sv
// Captures NUM_CNT 64-bit counters atomically on timer/software trigger and
// streams them out as one AXI-stream record (header + one word per counter).
module pktcnt_snapshot_sched
  import pktcnt_snap_pkg::*;
#(
  parameter int          NUM_CNT    = 4,
  parameter int          INTERVAL_W = 32,
  parameter logic [15:0] MAGIC      = MAGIC_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [INTERVAL_W-1:0]   interval,
  input  logic                    sw_trigger,
  input  logic                    clear_on_snap,
  input  logic [NUM_CNT*64-1:0]   cnt_in,
  output logic                    cnt_clear,
  output logic [63:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [31:0]             snap_count,
  output logic [31:0]             overrun_count
);

  localparam int WI_W = widx_w(NUM_CNT);

  state_e                     state_q;
  logic [NUM_CNT-1:0][63:0]   shadow_q;
  logic [WI_W-1:0]            widx_q;
  logic [63:0]                tdata_q;
  logic                       tvalid_q, tlast_q;
  logic [31:0]                seq_q, ovr_q;
  logic                       expire, trig, hs;
  logic [63:0]                nxt_word;

  snapshot_interval_timer #(.INTERVAL_W(INTERVAL_W)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .interval (interval),
    .expire   (expire)
  );

  assign trig = sw_trigger | expire;
  assign hs   = tvalid_q & m_axis_tready;

  // Word w+1 carries counter w; decoded mux keeps the index width independent of NUM_CNT.
  always_comb begin
    nxt_word = '0;
    for (int k = 0; k < NUM_CNT; k++)
      if (widx_q == WI_W'(k)) nxt_word = shadow_q[k];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      widx_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      seq_q    <= '0;
      ovr_q    <= '0;
    end else begin
      // Any trigger outside IDLE is dropped, including one on the final handshake.
      if (trig && state_q != IDLE && ovr_q != '1)
        ovr_q <= ovr_q + 32'd1;
      case (state_q)
        IDLE: if (trig) state_q <= CAPTURE;
        CAPTURE: begin
          shadow_q <= cnt_in;
          tdata_q  <= mk_header(MAGIC, 8'(NUM_CNT), seq_q);
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b0;
          widx_q   <= '0;
          state_q  <= SEND;
        end
        SEND: if (hs) begin
          if (tlast_q) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            seq_q    <= seq_q + 32'd1;
            state_q  <= IDLE;
          end else begin
            tdata_q <= nxt_word;
            tlast_q <= (widx_q == WI_W'(NUM_CNT - 1));
            widx_q  <= widx_q + WI_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Clear lands on the same edge that loads the shadow, so no event is lost or counted twice.
  assign cnt_clear     = (state_q == CAPTURE) & clear_on_snap;
  assign busy          = (state_q != IDLE);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  // Every emitted record bumps the sequence number, so it doubles as the snapshot count.
  assign snap_count    = seq_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_pktcnt_snapshot_sched.sv
// Directed bench for pktcnt_snapshot_sched: latency, record format, clear strobe,
// back-pressure, overruns, coincident triggers and mid-record reset.
module tb_pktcnt_snapshot_sched;
  localparam int NC = 4;

  logic              clk = 1'b0, resetn = 1'b0;
  logic [31:0]       interval = '0;
  logic              sw_trigger = 1'b0, clear_on_snap = 1'b0, tready = 1'b1;
  logic [NC*64-1:0]  cnt_in = '0;
  logic              cnt_clear, tvalid, tlast, busy;
  logic [63:0]       tdata;
  logic [31:0]       snap_count, overrun_count;

  pktcnt_snapshot_sched #(.NUM_CNT(NC), .INTERVAL_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .interval      (interval),
    .sw_trigger    (sw_trigger),
    .clear_on_snap (clear_on_snap),
    .cnt_in        (cnt_in),
    .cnt_clear     (cnt_clear),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .busy          (busy),
    .snap_count    (snap_count),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  bit rand_rdy = 0, ramp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: handshaken words, clear pulses, tvalid rises, and hold-while-stalled.
  logic [64:0] words[$];
  int          clr_cyc[$], vrise_cyc[$];
  logic [63:0] clr_val[$];
  logic        pv = 0, pstall = 0, plast = 0;
  logic [63:0] pdata = '0;

  always @(negedge clk) begin
    #1;
    if (!resetn) begin
      pstall = 0;
      pv     = 0;
    end else begin
      if (pstall) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", tdata, pdata);
        chk("hold_last", 64'(tlast), 64'(plast));
      end
      if (tvalid && !pv) vrise_cyc.push_back(cyc);
      if (cnt_clear) begin
        clr_cyc.push_back(cyc);
        clr_val.push_back(cnt_in[63:0]);
      end
      if (tvalid && tready) words.push_back({tlast, tdata});
      pstall = tvalid && !tready;
      pdata  = tdata;
      plast  = tlast;
      pv     = tvalid;
    end
  end

  task automatic step();
    @(negedge clk);
    if (rand_rdy) tready = ($urandom_range(0, 9) >= 3);
    if (ramp) cnt_in[63:0] = 64'(cyc);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    words.delete(); clr_cyc.delete(); vrise_cyc.delete(); clr_val.delete();
  endtask

  task automatic do_reset(input logic [31:0] iv);
    resetn = 0; interval = iv; sw_trigger = 0;
    steps(3);
    resetn = 1;
    clear_logs();
  endtask

  task automatic pulse_sw();
    sw_trigger = 1; step(); sw_trigger = 0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy && n < maxc) begin step(); n++; end
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic set_cnt(input logic [63:0] d0, d1, d2, d3);
    cnt_in = {d3, d2, d1, d0};
  endtask

  task automatic chk_rec(input string tag, input int base, input logic [31:0] seq,
                         input logic [63:0] d0, d1, d2, d3);
    logic [63:0] exp [5];
    exp[0] = {16'h0C47, 8'd4, 8'h00, seq};
    exp[1] = d0; exp[2] = d1; exp[3] = d2; exp[4] = d3;
    if (words.size() < base + 5) begin
      chk({tag, "_len"}, 64'(words.size()), 64'(base + 5));
      return;
    end
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("%s_w%0d", tag, j), words[base+j][63:0], exp[j]);
      chk($sformatf("%s_l%0d", tag, j), 64'(words[base+j][64]), 64'(j == 4));
    end
  endtask

  function automatic int n_last();
    int n = 0;
    foreach (words[i]) if (words[i][64]) n++;
    return n;
  endfunction

  function automatic logic [63:0] t3v(input int r, input int k);
    return 64'hA5A5_0000_0000_0000 + 64'(r * 16 + k);
  endfunction

  initial begin
    int t0, rel, n;

    // 1: basic record, latency, reset state
    set_cnt(1, 2, 3, 4);
    do_reset(0);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tlast", 64'(tlast), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_snap", 64'(snap_count), 0);
    chk("rst_ovr", 64'(overrun_count), 0);
    chk("rst_clr", 64'(cnt_clear), 0);
    t0 = cyc;
    pulse_sw();
    chk("t1_capture_busy", 64'(busy), 1);
    chk("t1_noclr", 64'(cnt_clear), 0);
    step();
    set_cnt('1, '1, '1, '1);
    steps(7);
    chk("t1_latency", (vrise_cyc.size() > 0) ? 64'(vrise_cyc[0] - t0) : '1, 64'd2);
    chk("t1_nwords", 64'(words.size()), 64'd5);
    chk_rec("t1", 0, 0, 1, 2, 3, 4);
    chk("t1_snap", 64'(snap_count), 1);

    // trigger on the last handshake is an overrun; the next cycle is accepted
    clear_logs();
    set_cnt(5, 6, 7, 8);
    t0 = cyc;
    pulse_sw();
    steps(5);
    sw_trigger = 1;
    step();
    set_cnt(9, 10, 11, 12);
    step();
    sw_trigger = 0;
    wait_idle(20, "b2b_timeout");
    steps(2);
    chk("b2b_ovr", 64'(overrun_count), 1);
    chk("b2b_lat2", (vrise_cyc.size() > 1) ? 64'(vrise_cyc[1] - t0) : '1, 64'd9);
    chk("b2b_nwords", 64'(words.size()), 64'd10);
    chk_rec("b2b_r0", 0, 1, 5, 6, 7, 8);
    chk_rec("b2b_r1", 5, 2, 9, 10, 11, 12);
    chk("b2b_snap", 64'(snap_count), 3);

    // 6: reset while beat 2 of SEND is on the bus
    clear_logs();
    set_cnt(1, 2, 3, 4);
    pulse_sw();
    step();
    step();
    resetn = 0;
    step();
    chk("t6_tvalid", 64'(tvalid), 0);
    chk("t6_tlast", 64'(tlast), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_snap", 64'(snap_count), 0);
    chk("t6_ovr", 64'(overrun_count), 0);
    chk("t6_partial", 64'(words.size()), 64'd1);
    chk("t6_no_tlast", 64'(n_last()), 0);
    step();
    resetn = 1;
    clear_logs();
    set_cnt(21, 22, 23, 24);
    pulse_sw();
    wait_idle(20, "t6_timeout");
    steps(2);
    chk_rec("t6_after", 0, 0, 21, 22, 23, 24);

    // 2: periodic snapshots with clear
    clear_on_snap = 1;
    set_cnt(0, 2, 3, 4);
    ramp = 1;
    do_reset(100);
    rel = cyc;
    steps(330);
    ramp = 0;
    chk("t2_nclr", 64'(clr_cyc.size()), 64'd3);
    chk("t2_first", (clr_cyc.size() > 0) ? 64'(clr_cyc[0] - rel) : '1, 64'd100);
    for (int i = 0; i < 3 && i < clr_cyc.size() && i < vrise_cyc.size(); i++) begin
      chk($sformatf("t2_clr_vs_valid%0d", i), 64'(vrise_cyc[i] - clr_cyc[i]), 64'd1);
      if (i > 0) chk($sformatf("t2_period%0d", i), 64'(clr_cyc[i] - clr_cyc[i-1]), 64'd100);
      chk_rec($sformatf("t2_r%0d", i), i * 5, 32'(i), clr_val[i], 2, 3, 4);
    end
    chk("t2_snap", 64'(snap_count), 3);
    clear_on_snap = 0;

    // 3: random back-pressure over four records
    do_reset(0);
    rand_rdy = 1;
    for (int r = 0; r < 4; r++) begin
      set_cnt(t3v(r, 0), t3v(r, 1), t3v(r, 2), t3v(r, 3));
      pulse_sw();
      wait_idle(200, $sformatf("t3_timeout%0d", r));
    end
    rand_rdy = 0;
    tready = 1;
    steps(2);
    chk("t3_nwords", 64'(words.size()), 64'd20);
    chk("t3_ntlast", 64'(n_last()), 64'd4);
    for (int r = 0; r < 4; r++)
      chk_rec($sformatf("t3_r%0d", r), r * 5, 32'(r), t3v(r, 0), t3v(r, 1), t3v(r, 2), t3v(r, 3));

    // 4: long stall; each expiry while busy is an overrun
    tready = 0;
    set_cnt(31, 32, 33, 34);
    do_reset(100);
    n = 0;
    while (!tvalid && n < 300) begin step(); n++; end
    chk("t4_start", 64'(tvalid), 1);
    steps(500);
    chk("t4_ovr_stalled", 64'(overrun_count), 5);
    tready = 1;
    steps(8);
    chk("t4_ovr", 64'(overrun_count), 5);
    chk("t4_snap", 64'(snap_count), 1);
    chk("t4_ntlast", 64'(n_last()), 1);
    chk_rec("t4", 0, 0, 31, 32, 33, 34);

    // 5: software trigger coincident with timer expiry
    set_cnt(41, 42, 43, 44);
    do_reset(50);
    steps(49);
    pulse_sw();
    steps(10);
    chk("t5_snap", 64'(snap_count), 1);
    chk("t5_ovr", 64'(overrun_count), 0);
    chk("t5_nwords", 64'(words.size()), 64'd5);
    chk_rec("t5", 0, 0, 41, 42, 43, 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
